// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: ALU operation encoding, base opcodes and the
// decoded bundle handed from decode to execute.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    alu_op_t     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        reg_write;
    logic        illegal;
    logic [31:0] pc;
  } decode_bundle_t;

  // alt selects the funct7=0x20 variant (SUB / SRA) where one exists
  function automatic alu_op_t funct3_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the ALU decode stage.
interface alu_decode_stage_if;
  import riscv_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        out_valid;
  logic        out_ready;
  alu_op_t     alu_op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        use_imm;
  logic        use_pc;
  logic        reg_write;
  logic        illegal;
  logic [31:0] pc_out;

  modport master (
    output in_valid, instr, pc, out_ready,
    input  in_ready, out_valid, alu_op, rs1, rs2, rd, imm,
           use_imm, use_pc, reg_write, illegal, pc_out
  );

  modport slave (
    input  in_valid, instr, pc, out_ready,
    output in_ready, out_valid, alu_op, rs1, rs2, rd, imm,
           use_imm, use_pc, reg_write, illegal, pc_out
  );

endinterface

// File: rtl/alu_decode_comb.sv
// Combinational RV32I ALU-instruction decoder (OP, OP-IMM, LUI, AUIPC).
// Anything it cannot decode comes out as an illegal bundle with zeroed controls.
import riscv_pkg::*;

module alu_decode_comb (
  input  logic [31:0]    instr,
  input  logic [31:0]    pc,
  output decode_bundle_t bundle
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_zero;
  logic       f7_alt;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign f7_zero = (funct7 == 7'h00);
  assign f7_alt  = (funct7 == 7'h20);

  decode_bundle_t d;
  logic           legal;

  always_comb begin
    d     = '0;
    d.pc  = pc;
    legal = 1'b0;
    // opcode includes instr[1:0], so non-32-bit encodings never match here
    case (opcode)
      OPC_OP: begin
        d.rs1    = instr[19:15];
        d.rs2    = instr[24:20];
        d.rd     = instr[11:7];
        d.alu_op = funct3_op(funct3, f7_alt);
        legal    = f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OPC_OP_IMM: begin
        d.rs1     = instr[19:15];
        d.rd      = instr[11:7];
        d.use_imm = 1'b1;
        d.imm     = {{20{instr[31]}}, instr[31:20]};
        d.alu_op  = funct3_op(funct3, 1'b0);
        legal     = 1'b1;
        if (funct3 == 3'b001) begin
          d.imm = {27'b0, instr[24:20]};
          legal = f7_zero;
        end else if (funct3 == 3'b101) begin
          d.imm    = {27'b0, instr[24:20]};
          d.alu_op = f7_alt ? ALU_SRA : ALU_SRL;
          legal    = f7_zero || f7_alt;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        d.rd      = instr[11:7];
        d.imm     = {instr[31:12], 12'b0};
        d.use_imm = 1'b1;
        d.use_pc  = (opcode == OPC_AUIPC);
        d.alu_op  = ALU_ADD;
        legal     = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    bundle = d;
    if (legal) begin
      bundle.reg_write = 1'b1;
    end else begin
      bundle         = '0;
      bundle.pc      = pc;
      bundle.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage between fetch and execute, 1-cycle latency, valid/ready both sides.
// ALU_DECODE_SKID_EN adds a skid entry so in_ready is a register instead of a path from out_ready.
import riscv_pkg::*;

module alu_decode_stage (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  alu_decode_stage_if.slave  bus
);

  decode_bundle_t dec;
  decode_bundle_t out_reg;
  logic           out_vld;
  logic           in_rdy;

  alu_decode_comb u_decode (
    .instr  (bus.instr),
    .pc     (bus.pc),
    .bundle (dec)
  );

`ifdef ALU_DECODE_SKID_EN
  decode_bundle_t skid_reg;
  logic           skid_vld;

  assign in_rdy = !skid_vld;

  // skid_vld implies out_vld; the skid entry is always older than any new input
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_reg  <= '0;
      skid_reg <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      if (bus.out_ready) begin
        out_reg  <= skid_reg;
        skid_vld <= 1'b0;
      end
    end else if (!out_vld || bus.out_ready) begin
      out_vld <= bus.in_valid;
      if (bus.in_valid) out_reg <= dec;
    end else if (bus.in_valid) begin
      skid_reg <= dec;
      skid_vld <= 1'b1;
    end
  end
`else
  assign in_rdy = !out_vld || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_reg <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (in_rdy) begin
      out_vld <= bus.in_valid;
      if (bus.in_valid) out_reg <= dec;
    end
  end
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.alu_op    = out_reg.alu_op;
  assign bus.rs1       = out_reg.rs1;
  assign bus.rs2       = out_reg.rs2;
  assign bus.rd        = out_reg.rd;
  assign bus.imm       = out_reg.imm;
  assign bus.use_imm   = out_reg.use_imm;
  assign bus.use_pc    = out_reg.use_pc;
  assign bus.reg_write = out_reg.reg_write;
  assign bus.illegal   = out_reg.illegal;
  assign bus.pc_out    = out_reg.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: directed instructions with hand-decoded results.
module tb_alu_decode_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  alu_decode_stage_if bus ();

  alu_decode_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        reg_write;
    logic        illegal;
  } vec_t;

  vec_t           vecs [14];
  decode_bundle_t exp_q [$];
  int             errors = 0;
  int             checks = 0;
  logic           last_in_ready;

  function automatic decode_bundle_t expect_of(input int i, input logic [31:0] p);
    decode_bundle_t b;
    b.alu_op    = alu_op_t'(vecs[i].op);
    b.rs1       = vecs[i].rs1;
    b.rs2       = vecs[i].rs2;
    b.rd        = vecs[i].rd;
    b.imm       = vecs[i].imm;
    b.use_imm   = vecs[i].use_imm;
    b.use_pc    = vecs[i].use_pc;
    b.reg_write = vecs[i].reg_write;
    b.illegal   = vecs[i].illegal;
    b.pc        = p;
    return b;
  endfunction

  function automatic decode_bundle_t actual();
    decode_bundle_t b;
    b.alu_op    = bus.alu_op;
    b.rs1       = bus.rs1;
    b.rs2       = bus.rs2;
    b.rd        = bus.rd;
    b.imm       = bus.imm;
    b.use_imm   = bus.use_imm;
    b.use_pc    = bus.use_pc;
    b.reg_write = bus.reg_write;
    b.illegal   = bus.illegal;
    b.pc        = bus.pc_out;
    return b;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bundle(input string name, input decode_bundle_t act, input decode_bundle_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, resolve the handshake just before the next posedge.
  task automatic step(input logic v, input int idx, input logic [31:0] p,
                      input logic ordy, input logic fl, input logic rs, output logic acc);
    @(negedge clk);
    rst           = rs;
    flush         = fl;
    bus.in_valid  = v;
    bus.instr     = v ? vecs[idx].instr : 32'h0;
    bus.pc        = p;
    bus.out_ready = ordy;
    #1;
    last_in_ready = bus.in_ready;
    acc = v && bus.in_ready && !fl && !rs;
    if (fl || rs) exp_q.delete();
    if (acc) exp_q.push_back(expect_of(idx, p));
  endtask

  // Monitor: pops on every output transfer and checks held bundles stay stable.
  initial begin
    decode_bundle_t snap;
    logic           held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (held) begin
        check_bit("hold_valid", bus.out_valid, 1'b1);
        check_bundle("hold_stable", actual(), snap);
      end
      held = 1'b0;
      if (rst === 1'b0 && flush === 1'b0 && bus.out_valid === 1'b1) begin
        if (bus.out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none at %0t", actual(), $time);
          end else begin
            check_bundle("out_bundle", actual(), exp_q.pop_front());
          end
        end else begin
          held = 1'b1;
          snap = actual();
        end
      end
    end
  end

  initial begin
    logic acc;
    logic ir [32];
    int   k;

    //               instr          op  rs1 rs2 rd  imm            ui pc rw il
    vecs[0]  = '{32'h002081B3, 4'd0, 5'd1, 5'd2, 5'd3, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0}; // add x3,x1,x2
    vecs[1]  = '{32'h407302B3, 4'd1, 5'd6, 5'd7, 5'd5, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0}; // sub x5,x6,x7
    vecs[2]  = '{32'hFFF00093, 4'd0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0}; // addi x1,x0,-1
    vecs[3]  = '{32'h40325213, 4'd7, 5'd4, 5'd0, 5'd4, 32'h3,        1'b1, 1'b0, 1'b1, 1'b0}; // srai x4,x4,3
    vecs[4]  = '{32'h12345137, 4'd0, 5'd0, 5'd0, 5'd2, 32'h12345000, 1'b1, 1'b0, 1'b1, 1'b0}; // lui x2
    vecs[5]  = '{32'h00000003, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1}; // lw
    vecs[6]  = '{32'h023100B3, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1}; // mul
    vecs[7]  = '{32'hABCDE517, 4'd0, 5'd0, 5'd0, 5'd10, 32'hABCDE000, 1'b1, 1'b1, 1'b1, 1'b0}; // auipc x10
    vecs[8]  = '{32'h7FF2C313, 4'd4, 5'd5, 5'd0, 5'd6, 32'h7FF,      1'b1, 1'b0, 1'b1, 1'b0}; // xori x6,x5,0x7ff
    vecs[9]  = '{32'h009433B3, 4'd9, 5'd8, 5'd9, 5'd7, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0}; // sltu x7,x8,x9
    vecs[10] = '{32'h40109093, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1}; // slli funct7=0x20
    vecs[11] = '{32'h002081B0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1}; // instr[1:0]=00
    vecs[12] = '{32'h007352B3, 4'd6, 5'd6, 5'd7, 5'd5, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0}; // srl x5,x6,x7
    vecs[13] = '{32'h003170B3, 4'd2, 5'd2, 5'd3, 5'd1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0}; // and x1,x2,x3

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.instr = 32'h0; bus.pc = 32'h0; bus.out_ready = 1'b0;

    // Reset state in the first cycle after rst deasserts
    step(1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    check_bit("reset_out_valid", bus.out_valid, 1'b0);
    check_bundle("reset_data", actual(), decode_bundle_t'('0));
    check_bit("reset_in_ready", bus.in_ready, 1'b1);

    // Full-rate stream through every directed vector
    for (int i = 0; i < 14; i++) begin
      step(1'b1, i, 32'h1000 + 32'(4 * i), 1'b1, 1'b0, 1'b0, acc);
      check_bit("stream_accept", acc, 1'b1);
    end
    for (int i = 0; i < 2; i++) step(1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Backpressure: out_ready low in cycles 1..3 while four instructions stream in
    k = 0;
    for (int c = 0; c < 32 && k < 4; c++) begin
      step(1'b1, k, 32'h2000 + 32'(4 * k), !(c >= 1 && c <= 3), 1'b0, 1'b0, acc);
      ir[c] = last_in_ready;
      if (acc) k++;
    end
    check_bit("bp_all_accepted", (k == 4), 1'b1);
`ifdef ALU_DECODE_SKID_EN
    check_bit("bp_in_ready_c1", ir[1], 1'b1);
`else
    check_bit("bp_in_ready_c1", ir[1], 1'b0);
`endif
    check_bit("bp_in_ready_c2", ir[2], 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    check_bit("bp_drained", (exp_q.size() == 0), 1'b1);

    // Flush while stalled, with an input offered in the flush cycle
    step(1'b1, 8, 32'h3000, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 9, 32'h3004, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 12, 32'h3008, 1'b0, 1'b1, 1'b0, acc);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    check_bit("flush_out_valid", bus.out_valid, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 13, 32'h300C, 1'b1, 1'b0, 1'b0, acc);
    check_bit("flush_recover_accept", acc, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

    // Reset mid-stream
    step(1'b1, 4, 32'h4000, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 5, 32'h4004, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 6, 32'h4008, 1'b1, 1'b0, 1'b1, acc);
    step(1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bundle("rst_data", actual(), decode_bundle_t'('0));
    check_bit("rst_in_ready", bus.in_ready, 1'b1);

    step(1'b1, 7, 32'h5000, 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
    check_bit("final_drained", (exp_q.size() == 0), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
